in_service_control: RTL and testbench

Acknowledge and in-service stage of the 8259A-compatible interrupt controller. It sits directly downstream of the priority resolver. It runs the two-pulse INTA handshake toward the CPU and commits the resolver's one-hot winner into the In-Service Register (ISR). It also pulses the IRR clear for that level, drives the vector byte, and executes EOI commands. It maintains the rotation pointer `highest_level_in_service` that feeds back into the resolver.

---
 rtl/pic_pkg.sv | 30 +++
 rtl/isr_priority_select.sv | 22 ++
 rtl/in_service_control.sv | 153 +++++++++++++++
 tb/tb_in_service_control.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-compatible interrupt controller.
package pic_pkg;

  localparam int unsigned LEVELS = 8;
  localparam int unsigned LVL_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } ack_state_t;

  // Index of the lowest set bit; callers pass one-hot values.
  function automatic logic [LVL_W-1:0] onehot_to_level(input logic [LEVELS-1:0] v);
    logic [LVL_W-1:0] lvl;
    lvl = '0;
    for (int i = LEVELS - 1; i >= 0; i--) begin
      if (v[i]) lvl = LVL_W'(i);
    end
    return lvl;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

endpackage

// File: rtl/isr_priority_select.sv
// Picks the highest-priority in-service bit, with priority starting one level past the rotation pointer.
module isr_priority_select
  import pic_pkg::*;
(
  input  logic [LEVELS-1:0] isr,
  input  logic [LEVELS-1:0] ptr,
  output logic [LEVELS-1:0] highest_c
);

  logic [LVL_W-1:0]  ptr_lvl;
  logic [LEVELS-1:0] isr_rot;
  logic [LEVELS-1:0] lowest_rot;

  // Rotate so the level after the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    ptr_lvl    = onehot_to_level(ptr);
    isr_rot    = rotl8(isr, 3'd7 - ptr_lvl);
    lowest_rot = isr_rot & (~isr_rot + 8'd1);
    highest_c  = rotl8(lowest_rot, ptr_lvl + 3'd1);
  end

endmodule

// File: rtl/in_service_control.sv
// INTA handshake, In-Service Register, EOI execution and vector drive for the 8259A-compatible controller.
module in_service_control
  import pic_pkg::*;
#(
  parameter int unsigned INTA_SYNC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inta_n,
  input  logic [LEVELS-1:0] interrupt,
  input  logic [4:0]        vector_base,
  input  logic              auto_eoi,
  input  logic              eoi_valid,
  input  logic              eoi_specific,
  input  logic [LVL_W-1:0]  eoi_level,
  input  logic              eoi_rotate,
  output logic              int_out,
  output logic [LEVELS-1:0] in_service_register,
  output logic [LEVELS-1:0] highest_level_in_service,
  output logic [LEVELS-1:0] clear_irr,
  output logic [7:0]        data_out,
  output logic              data_oe
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_ACK1  = 2'(ACK1);
  localparam logic [1:0] ST_WAIT2 = 2'(WAIT2);
  localparam logic [1:0] ST_ACK2  = 2'(ACK2);

  logic [INTA_SYNC-1:0] sync_q;
  logic                 hist_q;
  logic                 fall_c;
  logic                 rise_c;

  logic [1:0]           state_q, state_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 spur_q, spur_d;
  logic                 int_d;
  logic                 oe_d;
  logic [7:0]           dout_d;
  logic [LEVELS-1:0]    clr_d;
  logic [LEVELS-1:0]    ack_set;
  logic [LEVELS-1:0]    aeoi_clr;
  logic [LEVELS-1:0]    eoi_clr;
  logic [LEVELS-1:0]    isr_d;
  logic [LEVELS-1:0]    ptr_d;
  logic [LEVELS-1:0]    ns_sel_c;

  isr_priority_select u_sel (
    .isr       (in_service_register),
    .ptr       (highest_level_in_service),
    .highest_c (ns_sel_c)
  );

  // inta_n idles high, so the synchronizer and history flop reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[INTA_SYNC-2:0], inta_n};
      hist_q <= sync_q[INTA_SYNC-1];
    end
  end

  assign fall_c = hist_q & ~sync_q[INTA_SYNC-1];
  assign rise_c = ~hist_q & sync_q[INTA_SYNC-1];

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    spur_d   = spur_q;
    int_d    = 1'b0;
    oe_d     = data_oe;
    dout_d   = data_out;
    clr_d    = '0;
    ack_set  = '0;
    aeoi_clr = '0;
    case (state_q)
      ST_IDLE: begin
        int_d = |interrupt;
        if (fall_c) begin
          state_d = ST_ACK1;
          int_d   = 1'b0;
          if (interrupt == '0) begin
            level_d = 3'd7;
            spur_d  = 1'b1;
          end else begin
            level_d = onehot_to_level(interrupt);
            spur_d  = 1'b0;
            ack_set = 8'd1 << onehot_to_level(interrupt);
            clr_d   = 8'd1 << onehot_to_level(interrupt);
          end
        end
      end
      ST_ACK1: begin
        if (rise_c) state_d = ST_WAIT2;
      end
      ST_WAIT2: begin
        if (fall_c) begin
          state_d = ST_ACK2;
          oe_d    = 1'b1;
          dout_d  = {vector_base, level_q};
        end
      end
      ST_ACK2: begin
        dout_d = {vector_base, level_q};
        if (rise_c) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          if (auto_eoi && !spur_q) aeoi_clr = 8'd1 << level_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // EOI path; an acknowledge set of the same bit overrides any clear.
  always_comb begin
    eoi_clr = '0;
    ptr_d   = highest_level_in_service;
    if (eoi_valid) begin
      eoi_clr = eoi_specific ? (8'd1 << eoi_level) : ns_sel_c;
      if (eoi_rotate && (eoi_specific || (ns_sel_c != '0))) ptr_d = eoi_clr;
    end
    isr_d = (in_service_register & ~(eoi_clr | aeoi_clr)) | ack_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q                  <= ST_IDLE;
      level_q                  <= '0;
      spur_q                   <= 1'b0;
      int_out                  <= 1'b0;
      in_service_register      <= '0;
      highest_level_in_service <= 8'h80;
      clear_irr                <= '0;
      data_out                 <= '0;
      data_oe                  <= 1'b0;
    end else begin
      state_q                  <= state_d;
      level_q                  <= level_d;
      spur_q                   <= spur_d;
      int_out                  <= int_d;
      in_service_register      <= isr_d;
      highest_level_in_service <= ptr_d;
      clear_irr                <= clr_d;
      data_out                 <= dout_d;
      data_oe                  <= oe_d;
    end
  end

endmodule

// File: tb/tb_in_service_control.sv
// Directed bench for in_service_control: a per-cycle behavioural model plus hand-computed spot checks.
module tb_in_service_control;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       inta_n;
  logic [7:0] interrupt;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       eoi_rotate;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] ptr;
  logic [7:0] clear_irr;
  logic [7:0] data_out;
  logic       data_oe;

  int tests = 0;
  int fails = 0;

  in_service_control #(.INTA_SYNC(S)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .inta_n                   (inta_n),
    .interrupt                (interrupt),
    .vector_base              (vector_base),
    .auto_eoi                 (auto_eoi),
    .eoi_valid                (eoi_valid),
    .eoi_specific             (eoi_specific),
    .eoi_level                (eoi_level),
    .eoi_rotate               (eoi_rotate),
    .int_out                  (int_out),
    .in_service_register      (isr),
    .highest_level_in_service (ptr),
    .clear_irr                (clear_irr),
    .data_out                 (data_out),
    .data_oe                  (data_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 first ack, 2 between acks, 3 vector phase.
  int         m_phase = 0;
  int         m_lvl   = 0;
  int         m_ptr   = 7;
  bit         m_spur  = 0;
  logic [7:0] m_isr   = '0;
  logic       m_int   = 1'b0;
  logic [7:0] m_clr   = '0;
  logic [7:0] m_dout  = '0;
  logic       m_doe   = 1'b0;
  bit [S+1:0] smp     = '1;

  always @(posedge clk) begin
    bit         fall, rise, found;
    logic [7:0] eclr, aclr, set;
    int         nptr, l;
    if (reset) begin
      m_phase = 0; m_lvl = 0; m_ptr = 7; m_spur = 0;
      m_isr = '0; m_int = 1'b0; m_clr = '0; m_dout = '0; m_doe = 1'b0;
      smp = '1;
    end else begin
      smp  = {smp[S:0], inta_n};
      fall = !smp[S] && smp[S+1];
      rise = smp[S] && !smp[S+1];
      eclr = '0; aclr = '0; set = '0;
      nptr = m_ptr;
      if (eoi_valid) begin
        if (eoi_specific) begin
          eclr[eoi_level] = 1'b1;
          if (eoi_rotate) nptr = int'(eoi_level);
        end else begin
          found = 0;
          for (int k = 1; k <= 8; k++) begin
            l = (m_ptr + k) % 8;
            if (!found && m_isr[l]) begin
              found = 1;
              eclr[l] = 1'b1;
              if (eoi_rotate) nptr = l;
            end
          end
        end
      end
      m_clr = '0;
      m_int = 1'b0;
      case (m_phase)
        0: begin
          m_int = |interrupt;
          if (fall) begin
            m_int = 1'b0;
            m_phase = 1;
            if (interrupt == 8'h00) begin
              m_lvl = 7; m_spur = 1;
            end else begin
              m_spur = 0;
              for (int i = 7; i >= 0; i--) if (interrupt[i]) m_lvl = i;
              set[m_lvl] = 1'b1;
              m_clr = set;
            end
          end
        end
        1: if (rise) m_phase = 2;
        2: if (fall) begin
          m_phase = 3; m_doe = 1'b1; m_dout = {vector_base, 3'(m_lvl)};
        end
        default: begin
          m_dout = {vector_base, 3'(m_lvl)};
          if (rise) begin
            m_phase = 0; m_doe = 1'b0;
            if (auto_eoi && !m_spur) aclr[m_lvl] = 1'b1;
          end
        end
      endcase
      m_isr = (m_isr & ~(eclr | aclr)) | set;
      m_ptr = nptr;
    end
    #1;
    chk("model int_out", {7'd0, int_out}, {7'd0, m_int});
    chk("model isr", isr, m_isr);
    chk("model ptr", ptr, 8'd1 << m_ptr);
    chk("model clear_irr", clear_irr, m_clr);
    chk("model data_oe", {7'd0, data_oe}, {7'd0, m_doe});
    chk("model data_out", data_out, m_dout);
  end

  task automatic inta(input logic v);
    @(negedge clk);
    inta_n = v;
    repeat (S + 1) @(posedge clk);
    #1;
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl, input logic rot);
    @(negedge clk);
    eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lvl; eoi_rotate = rot;
    @(negedge clk);
    eoi_valid = 1'b0; eoi_rotate = 1'b0;
  endtask

  task automatic handshake(input logic [7:0] irq);
    @(negedge clk);
    interrupt = irq;
    inta(1'b0);
    @(negedge clk);
    interrupt = 8'h00;
    inta(1'b1);
    inta(1'b0);
    inta(1'b1);
  endtask

  // Drives a first fall that lands on the same edge as a specific EOI of lvl.
  task automatic collide(input logic [7:0] irq, input logic [2:0] lvl);
    @(negedge clk);
    interrupt = irq;
    inta_n    = 1'b0;
    repeat (S) @(negedge clk);
    eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = lvl; eoi_rotate = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; inta_n = 1'b1; interrupt = '0; vector_base = 5'h08;
    auto_eoi = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = '0; eoi_rotate = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset int_out", {7'd0, int_out}, 8'h00);
    chk("reset isr", isr, 8'h00);
    chk("reset ptr", ptr, 8'h80);
    chk("reset data_oe", {7'd0, data_oe}, 8'h00);

    // Basic two-pulse handshake on IR2
    @(negedge clk);
    interrupt = 8'h04;
    @(posedge clk); #1;
    chk("basic int_out", {7'd0, int_out}, 8'h01);
    inta(1'b0);
    chk("basic clear_irr", clear_irr, 8'h04);
    chk("basic isr", isr, 8'h04);
    chk("basic int_out drop", {7'd0, int_out}, 8'h00);
    @(posedge clk); #1;
    chk("basic clear_irr one cycle", clear_irr, 8'h00);
    @(negedge clk);
    interrupt = 8'h00;
    inta(1'b1);
    inta(1'b0);
    chk("basic data_oe", {7'd0, data_oe}, 8'h01);
    chk("basic vector", data_out, 8'h42);
    chk("basic int_out ack2", {7'd0, int_out}, 8'h00);
    inta(1'b1);
    chk("basic data_oe off", {7'd0, data_oe}, 8'h00);
    eoi(1'b1, 3'd2, 1'b0);
    chk("basic specific eoi", isr, 8'h00);

    // Automatic EOI on IR7
    auto_eoi = 1'b1;
    @(negedge clk);
    interrupt = 8'h80;
    inta(1'b0);
    chk("aeoi isr set", isr, 8'h80);
    @(negedge clk);
    interrupt = 8'h00;
    inta(1'b1);
    inta(1'b0);
    chk("aeoi vector", data_out, 8'h47);
    inta(1'b1);
    chk("aeoi isr cleared", isr, 8'h00);
    auto_eoi = 1'b0;

    // Non-specific EOI with rotation
    handshake(8'h02);
    handshake(8'h08);
    chk("rot isr pre", isr, 8'h0A);
    eoi(1'b0, 3'd0, 1'b1);
    chk("rot1 isr", isr, 8'h08);
    chk("rot1 ptr", ptr, 8'h02);
    eoi(1'b0, 3'd0, 1'b1);
    chk("rot2 isr", isr, 8'h00);
    chk("rot2 ptr", ptr, 8'h08);
    eoi(1'b0, 3'd0, 1'b1);
    chk("rot empty ptr", ptr, 8'h08);

    // Spurious acknowledge: request withdrawn as inta_n falls
    @(negedge clk);
    interrupt = 8'h04;
    @(negedge clk);
    interrupt = 8'h00;
    inta_n    = 1'b0;
    repeat (S + 1) @(posedge clk);
    #1;
    chk("spur isr", isr, 8'h00);
    chk("spur clear_irr", clear_irr, 8'h00);
    inta(1'b1);
    inta(1'b0);
    chk("spur vector", data_out, 8'h47);
    inta(1'b1);

    // Set and specific EOI of the same bit on one edge: set wins
    collide(8'h08, 3'd3);
    chk("coll same isr", isr, 8'h08);
    chk("coll same clear_irr", clear_irr, 8'h08);
    @(negedge clk);
    eoi_valid = 1'b0; interrupt = 8'h00;
    inta(1'b1); inta(1'b0); inta(1'b1);
    handshake(8'h20);
    chk("coll pre isr", isr, 8'h28);
    eoi(1'b1, 3'd3, 1'b0);
    collide(8'h08, 3'd5);
    chk("coll diff isr", isr, 8'h08);
    @(negedge clk);
    eoi_valid = 1'b0; interrupt = 8'h00;
    inta(1'b1); inta(1'b0); inta(1'b1);

    // Reset while driving the vector
    @(negedge clk);
    interrupt = 8'h01;
    inta(1'b0);
    @(negedge clk);
    interrupt = 8'h00;
    inta(1'b1);
    inta(1'b0);
    chk("rst pre data_oe", {7'd0, data_oe}, 8'h01);
    chk("rst pre vector", data_out, 8'h40);
    chk("rst pre isr", isr, 8'h09);
    @(negedge clk);
    reset  = 1'b1;
    inta_n = 1'b1;
    #1;
    chk("rst data_oe", {7'd0, data_oe}, 8'h00);
    chk("rst int_out", {7'd0, int_out}, 8'h00);
    chk("rst isr", isr, 8'h00);
    chk("rst ptr", ptr, 8'h80);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (S + 3) @(posedge clk);
    #1;
    chk("rst stays idle", {7'd0, data_oe}, 8'h00);
    handshake(8'h10);
    chk("post rst isr", isr, 8'h10);

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
